// File: rtl/mem_port_arbiter.sv
// Arbiter and sequencer for the single-ported unified memory shared by
// instruction fetch and data access, with fetch starvation guard and timeout.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned TIMEOUT    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, state_next;
    logic          owner_d;     // 1 = data port owns the current transaction
    logic          lat_we;
    logic          err_flag;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          any_req, grant_d, tmo_hit;

    always_comb begin
        any_req    = if_req | d_req;
        grant_d    = d_req & ~(if_req & (starve_cnt == SW'(STARVE_MAX)));
        tmo_hit    = (tmo_cnt == TW'(TIMEOUT - 1));
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (mem_ready || tmo_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state != IDLE);
        mem_en = (state == ISSUE);
        mem_we = (state == ISSUE) & lat_we;
        if_ack = (state == RESP) & ~owner_d;
        d_ack  = (state == RESP) & owner_d;
        if_err = (state == RESP) & ~owner_d & err_flag;
        d_err  = (state == RESP) & owner_d & err_flag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_d    <= 1'b0;
            lat_we     <= 1'b0;
            err_flag   <= 1'b0;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner_d  <= grant_d;
                    lat_we   <= grant_d & d_we;
                    err_flag <= 1'b0;
                    mem_addr <= grant_d ? d_addr : if_addr;
                    // Fetch grants leave the write-data bus at its last value.
                    if (grant_d) begin
                        mem_wdata <= d_wdata;
                        if (if_req && starve_cnt != SW'(STARVE_MAX))
                            starve_cnt <= starve_cnt + SW'(1);
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                ISSUE: tmo_cnt <= '0;
                WAIT: begin
                    if (mem_ready) begin
                        if (!lat_we) begin
                            if (owner_d) d_rdata  <= mem_rdata;
                            else         if_rdata <= mem_rdata;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                        if (tmo_hit) begin
                            err_flag <= 1'b1;
                            if (owner_d) d_rdata  <= '0;
                            else         if_rdata <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbiter and sequencer for the CPU's single-ported unified memory, which serves both instruction fetch (IF stage) and data access (MEM stage, LD/ST). Two requesters share the port through a req/ack handshake. Data access has priority, with a starvation guard for fetch. A timeout watchdog stops a silent memory from hanging the pipeline.

Parameters:
ADDR_W, 10, memory word-address width
DATA_W, 32, data word width
STARVE_MAX, 3, consecutive data grants allowed while fetch waits before fetch is forced
TIMEOUT, 8, maximum cycles spent in WAIT before an error response

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  ADDR_W  fetch address, stable while if_req=1
if_rdata  out  DATA_W  registered fetched word
if_ack  out  1  one-cycle completion pulse to fetch
if_err  out  1  one-cycle timeout flag, coincident with if_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1=store, 0=load; stable while d_req=1
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  registered load result
d_ack  out  1  one-cycle completion pulse to data port
d_err  out  1  one-cycle timeout flag, coincident with d_ack
mem_en  out  1  one-cycle access strobe to memory
mem_we  out  1  write enable, valid with mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
mem_ready  in  1  memory completion, at least 1 cycle after mem_en
busy  out  1  high whenever state is not IDLE

Behaviour:
- The single clock is clk. reset is asynchronous and active-high.
- Reset: state=IDLE. All outputs are 0, including rdata registers. The starvation and timeout counters are 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, no requests: stay in IDLE.
- IDLE, request present: select an owner, latch owner, we, addr and wdata, then go to ISSUE.
  - Arbitration: if only one req is present, that port wins.
  - Both present: data wins, unless starve_cnt==STARVE_MAX, in which case fetch wins.
  - Fetch grants always use we=0.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) when data is granted while if_req=1.
  - Clears on any fetch grant.
  - Unchanged when data is granted with if_req=0.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we/mem_addr/mem_wdata driven from the latched request.
  - Next state is WAIT; tmo_cnt cleared.
- Outside ISSUE: mem_en=0 and mem_we=0. mem_addr/mem_wdata hold their last value.
- WAIT:
  - mem_ready=1: go to RESP; capture mem_rdata into the owner's rdata register, for reads only. Writes leave d_rdata unchanged.
  - Otherwise tmo_cnt increments. On reaching TIMEOUT, go to RESP with the owner's rdata=0 and the err flag armed.
- mem_ready is ignored in every state except WAIT.
- RESP (exactly 1 cycle): owner's ack=1, plus err=1 if a timeout occurred; next state is IDLE. The requester deasserts req by the edge ending RESP.
- Minimum latency: req sampled at edge N → mem_en in cycle N+1 → WAIT cycle N+2 (mem_ready here) → ack in cycle N+3.
- Throughput: one access per 4 cycles minimum (IDLE, ISSUE, WAIT, RESP).
- The non-owner port's req is left pending; its ack/err/rdata are untouched.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. A late mem_ready is ignored because the FSM is in IDLE.
- busy=1 in ISSUE, WAIT and RESP.

Test Plan:
- Single fetch: if_addr=0x005, mem_ready 1 cycle after mem_en with mem_rdata=0xDEADBEEF → one mem_en pulse (mem_addr=0x005, mem_we=0); if_ack pulses 3 cycles after req is sampled; if_rdata=0xDEADBEEF; if_err=0.
- Store: d_we=1, d_addr=0x00B, d_wdata=0x12345678 → mem_en=1 and mem_we=1 with matching addr/wdata; one d_ack; d_rdata keeps its prior value.
- Contention: both req held continuously (each re-asserted after its ack), STARVE_MAX=3 → grant order D,D,D,F,D,D,D,F. No grant is issued to a port that is mid-handshake.
- Variable latency: load at 0x00A, mem_ready 5 cycles after mem_en with 0x0000FFFF → d_ack the cycle after mem_ready; d_rdata=0x0000FFFF; busy high throughout.
- Timeout: load, mem_ready never asserted, TIMEOUT=8 → d_ack=1 and d_err=1 together after 8 WAIT cycles; d_rdata=0; FSM returns to IDLE and accepts the next request.
- Reset during WAIT: assert reset → all outputs 0 asynchronously; mem_ready pulsed after release → no ack; the next request completes normally.
